// File: rtl/led_seq_pkg.sv
// Shared encodings for the one-hot LED sequencer: the external mode code and
// the internal state machine states.
package led_seq_pkg;

    localparam int MODE_W = 2;

    // External mode input encoding.
    typedef enum logic [MODE_W-1:0] {
        MODE_DIRECT = 2'b00,
        MODE_SWEEP  = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_OFF    = 2'b11
    } mode_e;

    // Sequencer states. S_UP/S_DOWN carry the bounce direction; SWEEP only
    // ever uses S_UP.
    typedef enum logic [1:0] {
        S_OFF    = 2'b00,
        S_DIRECT = 2'b01,
        S_UP     = 2'b10,
        S_DOWN   = 2'b11
    } state_e;

endpackage

// File: rtl/led_seq_tick.sv
// Step-tick prescaler: counts enabled cycles 0..PRESCALE-1 and raises tick on
// the terminal count. clr restarts the count and suppresses that cycle's tick.
module led_seq_tick #(
    parameter int PRESCALE = 3_125_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int              CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt;
    logic             at_last;

    assign at_last = (cnt == LAST);

    // NOTE: tick is combinational from the counter, so it is gated by rst as
    // well; otherwise PRESCALE=1 would pulse tick while reset is held.
    assign tick = en & ~clr & ~rst & at_last;

    // Prescale counter: frozen when disabled, restarted on clr or wrap.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            if (clr || at_last) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/onehot_led_sequencer.sv
// One-hot LED sequencer: drives a registered one-hot (or all-zero) pattern
// from a position register that is either set directly, swept upward, or
// bounced between the ends, stepping on prescaler ticks.
module onehot_led_sequencer
    import led_seq_pkg::*;
#(
    parameter  int N_OUT    = 8,
    parameter  int PRESCALE = 3_125_000,
    localparam int SEL_W    = $clog2(N_OUT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [SEL_W-1:0]  sel,
    input  logic              load,
    output logic [N_OUT-1:0]  bin,
    output logic [SEL_W-1:0]  pos,
    output logic              tick
);

    localparam logic [SEL_W-1:0] POS_MAX = SEL_W'(N_OUT);
    localparam logic [SEL_W-1:0] POS_ONE = SEL_W'(1);

    mode_e             mode_cur;
    mode_e             mode_q;
    logic              mode_chg;
    logic              step_tick;
    state_e            state;
    state_e            state_n;
    logic [SEL_W-1:0]  pos_n;
    logic [SEL_W-1:0]  load_pos;
    logic [N_OUT-1:0]  dec;
    logic [N_OUT-1:0]  bin_n;

    assign mode_cur = mode_e'(mode);

    // Leaving reset counts as coming from OFF, so the first edge with any
    // other mode is treated as a mode change.
    assign mode_chg = (mode_cur != mode_q);

    // A load position beyond the last output saturates at the last output.
    assign load_pos = (sel > POS_MAX) ? POS_MAX : sel;

    led_seq_tick #(
        .PRESCALE (PRESCALE)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (mode_chg),
        .tick (step_tick)
    );

    assign tick = step_tick;

    // Remember the last mode seen on an enabled edge to detect mode changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_OFF;
        end else if (en) begin
            mode_q <= mode_cur;
        end
    end

    // Next-state and next-position logic.
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_n = state;
        pos_n   = pos;
        if (en) begin
            case (mode_cur)
                MODE_OFF: begin
                    state_n = S_OFF;
                end
                MODE_DIRECT: begin
                    state_n = S_DIRECT;
                    pos_n   = (sel > POS_MAX) ? '0 : sel;
                end
                MODE_SWEEP: begin
                    state_n = S_UP;
                    if (load) begin
                        pos_n = load_pos;
                    end else if (step_tick) begin
                        pos_n = (pos >= POS_MAX) ? POS_ONE : pos + POS_ONE;
                    end
                end
                MODE_BOUNCE: begin
                    if (load) begin
                        pos_n   = load_pos;
                        state_n = S_UP;
                    end else if (mode_chg) begin
                        state_n = S_UP;
                    end else if (step_tick) begin
                        if ((state == S_UP && pos >= POS_MAX) ||
                            (state == S_DOWN && pos > POS_ONE)) begin
                            pos_n   = pos - POS_ONE;
                            state_n = (pos_n <= POS_ONE) ? S_UP : S_DOWN;
                        end else begin
                            pos_n   = pos + POS_ONE;
                            state_n = (pos_n >= POS_MAX) ? S_DOWN : S_UP;
                        end
                    end
                end
                default: begin
                    state_n = S_OFF;
                end
            endcase
        end
    end

    // Position decode: position k lights output bit k-1, position 0 lights none.
    always_comb begin
        dec = '0;
        for (int k = 0; k < N_OUT; k++) begin
            dec[k] = (pos_n == SEL_W'(k + 1));
        end
    end

    assign bin_n = (state_n == S_OFF) ? '0 : dec;

    // State, position and pattern registered together so bin tracks pos.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_OFF;
            pos   <= '0;
            bin   <= '0;
        end else if (en) begin
            state <= state_n;
            pos   <= pos_n;
            bin   <= bin_n;
        end
    end

endmodule

// File: tb/tb_onehot_led_sequencer.sv
// Scoreboard bench for onehot_led_sequencer (N_OUT=8, PRESCALE=4): the
// stimulus side runs a behavioural model and queues the expected outputs for
// each cycle; a monitor on the falling edge pops and compares.
module tb_onehot_led_sequencer;
    import led_seq_pkg::*;

    localparam int N_OUT    = 8;
    localparam int PRESCALE = 4;
    localparam int SEL_W    = $clog2(N_OUT + 1);

    typedef struct {
        logic [SEL_W-1:0] pos;
        logic [N_OUT-1:0] bin;
        logic             tick;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             en;
    logic [1:0]       mode;
    logic [SEL_W-1:0] sel;
    logic             load;
    logic [N_OUT-1:0] bin;
    logic [SEL_W-1:0] pos;
    logic             tick;

    int n_checks = 0;
    int n_pass   = 0;

    exp_t sb_q[$];

    // Behavioural model state
    int         m_pos;
    int         m_dir;
    int         m_cnt;
    logic [1:0] m_prev;
    bit         m_off;

    onehot_led_sequencer #(
        .N_OUT    (N_OUT),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .mode (mode),
        .sel  (sel),
        .load (load),
        .bin  (bin),
        .pos  (pos),
        .tick (tick)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [N_OUT-1:0] exp_bin(input int p, input bit off);
        logic [N_OUT-1:0] v;
        v = '0;
        if (!off && p > 0) v[p-1] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        m_pos  = 0;
        m_dir  = 1;
        m_cnt  = 0;
        m_prev = MODE_OFF;
        m_off  = 1'b1;
    endtask

    // Bounce: move one step in the current direction, reversing at the ends.
    task automatic model_bounce();
        if (m_pos >= N_OUT) m_dir = -1;
        else if (m_pos <= 1 && m_dir < 0) m_dir = 1;
        m_pos = m_pos + m_dir;
        if (m_pos == N_OUT) m_dir = -1;
        else if (m_pos == 1) m_dir = 1;
    endtask

    // Apply one cycle of inputs (called at posedge+1), queue the outputs the
    // DUT must show during this cycle, then advance the model past the edge.
    task automatic step(input logic e, input logic [1:0] m, input logic [SEL_W-1:0] s, input logic l);
        exp_t it;
        bit   chg;
        bit   tk;
        en   = e;
        mode = m;
        sel  = s;
        load = l;
        chg = (m != m_prev);
        tk  = e && !chg && (m_cnt == PRESCALE - 1);
        it.pos  = SEL_W'(m_pos);
        it.bin  = exp_bin(m_pos, m_off);
        it.tick = tk;
        sb_q.push_back(it);
        if (e) begin
            m_cnt  = chg ? 0 : (m_cnt + 1) % PRESCALE;
            m_prev = m;
            case (m)
                MODE_OFF: m_off = 1'b1;
                MODE_DIRECT: begin
                    m_off = 1'b0;
                    m_pos = (int'(s) <= N_OUT) ? int'(s) : 0;
                end
                default: begin
                    m_off = 1'b0;
                    if (chg) m_dir = 1;
                    if (l) begin
                        m_pos = (int'(s) > N_OUT) ? N_OUT : int'(s);
                        m_dir = 1;
                    end else if (tk) begin
                        if (m == MODE_SWEEP) m_pos = (m_pos % N_OUT) + 1;
                        else model_bounce();
                    end
                end
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    // Assert reset in the middle of a cycle, check the asynchronous clear,
    // then release it just after the next edge with the given mode applied.
    task automatic do_reset(input logic [1:0] m_after);
        #2 rst = 1'b1;
        #1;
        check("rst_async_pos", pos, 0);
        check("rst_async_bin", bin, 0);
        check("rst_async_tick", tick, 0);
        @(posedge clk);
        #1;
        check("rst_hold_bin", bin, 0);
        mode = m_after;
        load = 1'b0;
        rst  = 1'b0;
        model_reset();
    endtask

    // Monitor: compare the queued expectation every falling edge
    initial begin
        exp_t it;
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                it = sb_q.pop_front();
                check("pos", pos, it.pos);
                check("bin", bin, it.bin);
                check("tick", tick, it.tick);
                check("bin_onehot", ($countones(bin) <= 1), 1);
            end
        end
    end

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        logic [1:0]       cur_mode;
        logic [SEL_W-1:0] rsel;
        rst  = 1'b1;
        en   = 1'b0;
        mode = MODE_OFF;
        sel  = '0;
        load = 1'b0;
        model_reset();
        #3;
        check("reset_pos", pos, 0);
        check("reset_bin", bin, 0);
        check("reset_tick", tick, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // DIRECT: in-range, out-of-range, ignored load, boundaries
        step(1, MODE_DIRECT, 3, 0);
        check("direct_sel3_bin", bin, 8'b0000_0100);
        step(1, MODE_DIRECT, 9, 0);
        check("direct_sel9_bin", bin, 8'h00);
        step(1, MODE_DIRECT, 9, 1);
        step(1, MODE_DIRECT, 8, 0);
        step(1, MODE_DIRECT, 0, 0);
        step(1, MODE_DIRECT, 1, 0);
        step(1, MODE_DIRECT, 5, 0);

        // SWEEP from reset: nine ticks walk 1..8 and wrap back to 1
        do_reset(MODE_SWEEP);
        for (int i = 0; i < 40; i++) step(1, MODE_SWEEP, SEL_W'($urandom_range(0, 15)), 0);
        check("sweep_wrap_pos", pos, 1);
        check("sweep_wrap_bin", bin, 8'h01);

        // BOUNCE from reset: sixteen ticks go 1..8, 7..1, then 2
        do_reset(MODE_BOUNCE);
        for (int i = 0; i < 66; i++) step(1, MODE_BOUNCE, '0, 0);
        check("bounce16_pos", pos, 2);

        // Load coincident with a tick while descending through 6
        for (int i = 0; i < 200 && !(m_pos == 6 && m_dir < 0 && m_cnt == PRESCALE - 1); i++)
            step(1, MODE_BOUNCE, '0, 0);
        step(1, MODE_BOUNCE, 12, 1);
        check("load_sat_pos", pos, 8);
        for (int i = 0; i < 4; i++) step(1, MODE_BOUNCE, '0, 0);
        check("load_turn_pos", pos, 7);

        // Enable low freezes everything mid-sweep
        do_reset(MODE_SWEEP);
        for (int i = 0; i < 200 && m_pos != 5; i++) step(1, MODE_SWEEP, '0, 0);
        for (int i = 0; i < 10; i++)
            step(0, MODE_SWEEP, SEL_W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        check("freeze_pos", pos, 5);
        for (int i = 0; i < 20 && m_pos != 6; i++) step(1, MODE_SWEEP, '0, 0);

        // Reset mid-sweep at position 4, then stay OFF
        for (int i = 0; i < 200 && m_pos != 4; i++) step(1, MODE_SWEEP, '0, 0);
        do_reset(MODE_OFF);
        for (int i = 0; i < 8; i++) step(1, MODE_OFF, SEL_W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));

        // Randomised traffic: sparse mode changes, random loads and enables
        cur_mode = MODE_SWEEP;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) cur_mode = 2'($urandom_range(0, 3));
            rsel = SEL_W'($urandom_range(0, 15));
            step(($urandom_range(0, 7) != 0), cur_mode, rsel, ($urandom_range(0, 7) == 0));
        end

        @(negedge clk);
        #1;
        check("scoreboard_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/onehot_led_sequencer.md
ONEHOT_LED_SEQUENCER -- requirements
Module: onehot_led_sequencer

Interface
REQ-001 Parameter N_OUT, default 8: number of one-hot outputs; legal range >= 2.
REQ-002 Parameter PRESCALE, default 3_125_000: clock cycles per step tick; legal range >= 1.
REQ-003 Derived localparam SEL_W = $clog2(N_OUT+1): position/select width.
REQ-004 clk  input  1  single system clock, all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 en  input  1  global enable; low freezes all state.
REQ-007 mode  input  2  00 DIRECT, 01 SWEEP, 10 BOUNCE, 11 OFF.
REQ-008 sel  input  SEL_W  direct select / load position; 0 = all off, k = output bit k-1.
REQ-009 load  input  1  in SWEEP/BOUNCE, loads pos from sel.
REQ-010 bin  output  N_OUT  registered one-hot (or all-zero) pattern.
REQ-011 pos  output  SEL_W  current position register, range 0..N_OUT.
REQ-012 tick  output  1  one-cycle pulse per prescaler wrap.

Function
REQ-013 Decode rule: pos 0 -> bin all zero; pos k (1..N_OUT) -> only bin[k-1] set; bin SHALL never have more than one bit set.
REQ-014 bin and pos SHALL be registered together; bin always equals decode(pos) of the same cycle.
REQ-015 Prescaler: counter 0..PRESCALE-1 increments when en=1; tick=1 on the cycle counter == PRESCALE-1, counter then wraps to 0; PRESCALE=1 gives tick every enabled cycle.
REQ-016 Any change of mode SHALL clear the prescaler counter on the following edge; no tick on that edge.
REQ-017 State machine states: S_OFF, S_DIRECT, S_UP, S_DOWN; mode 11 -> S_OFF, 00 -> S_DIRECT, 01 -> S_UP, 10 -> S_UP on entry then S_UP/S_DOWN per REQ-021.
REQ-018 S_DIRECT: every enabled cycle pos <= sel if sel <= N_OUT, else 0; latency sel -> bin exactly 1 clock; tick ignored.
REQ-019 S_OFF: bin forced to zero; pos held unchanged; tick still generated.
REQ-020 SWEEP: on tick pos <= pos+1; pos N_OUT wraps to 1; pos 0 advances to 1.
REQ-021 BOUNCE: in S_UP on tick pos+1, entering S_DOWN when pos reaches N_OUT; in S_DOWN on tick pos-1, entering S_UP when pos reaches 1; pos 0 advances to 1 in S_UP.
REQ-022 load=1 in SWEEP/BOUNCE: pos <= min(sel, N_OUT); direction set to S_UP; load has priority over a coincident tick (tick step discarded).
REQ-023 load ignored in DIRECT and OFF.
REQ-024 en=0: prescaler, pos, bin, state all hold; tick=0; load ignored.

Reset
REQ-025 On rst high, immediately and without a clock: bin=0, pos=0, tick=0, prescaler=0, state=S_OFF.
REQ-026 Release of rst SHALL be sampled synchronously; first active edge evaluates mode normally; reset mid-sweep discards position and direction.

Structure
REQ-027 Mode encodings and state encodings SHALL live in shared package led_seq_pkg.
REQ-028 Prescaler SHALL be a sub-module led_seq_tick (params PRESCALE; ports clk, rst, en, clr, tick).
REQ-029 Decode logic SHALL be a parameterised loop, no per-N case tables.

Verification (N_OUT=8, PRESCALE=4)
REQ-030 DIRECT, sel=3 then sel=9 -> bin=8'b0000_0100 one clock later, then 8'h00 (out-of-range).
REQ-031 SWEEP from reset, en=1 -> tick every 4th cycle; pos 1,2,...,8,1; bin walks bit0..bit7 and wraps to bit0.
REQ-032 BOUNCE, 16 ticks -> pos 1..8 then 7..1 then 2; bin never multi-hot.
REQ-033 BOUNCE at pos 6 in S_DOWN, load=1 sel=12 coincident with tick -> pos=8, state S_UP; next tick turns to S_DOWN, pos=7.
REQ-034 SWEEP at pos 5, en=0 for 10 cycles -> pos, bin, prescaler frozen, tick=0; resumes at 6 on next tick.
REQ-035 rst asserted mid-cycle during SWEEP pos 4 -> bin=0, pos=0 before next clock edge; after release with mode OFF bin stays 0.
